pts_converter: RTL and testbench

PTS_CONVERTER -- requirements
Module: pts_converter

---
 rtl/pts_converter.sv | 104 ++++++++++
 tb/tb_pts_converter.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/pts_converter.sv
// -----------------------------------------------------------------------------
// pts_converter
//
// Parallel-to-serial converter. A one-cycle start strobe (en) launches a
// 16-byte frame: four 32-bit words presented on d0..d3 are sampled one every
// four cycles and emitted byte by byte on data_out (d0 first, d3 last). While
// idle, data_out simply registers the bypass byte data_in.
//
// Ports
//   clk         in   1  rising-edge clock for all state
//   rst         in   1  synchronous active-high reset, highest priority
//   en          in   1  start-of-frame strobe, honoured only while idle
//   d0..d3      in   8  parallel word, d0 is the first byte out
//   data_in     in   8  bypass byte, passed to data_out while idle
//   data_out    out  8  registered serial byte stream
//   dbg_state_o out  1  current FSM state (1 = BUSY), for observation only
//
// Handshake: there is no back-pressure. en is a single-edge request sampled
// only in IDLE; once accepted the frame runs for exactly 16 edges and the
// word inputs must be valid at the sampling edges (k+1, k+5, k+9, k+13 for
// an en accepted at edge k). No ready/ack is returned.
// -----------------------------------------------------------------------------
module pts_converter (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] d0,
  input  logic [7:0] d1,
  input  logic [7:0] d2,
  input  logic [7:0] d3,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       dbg_state_o
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q,   cnt_d;
  logic [23:0] hold_q,  hold_d;
  logic [7:0]  dout_q,  dout_d;

  // State and datapath registers. Reset wins over everything, including a
  // frame in progress, so an aborted frame emits no further bytes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      hold_q  <= 24'd0;
      dout_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      dout_q  <= dout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    dout_d  = dout_q;

    unique case (state_q)
      IDLE: begin
        // Bypass is active on every idle edge, including the start edge.
        dout_d = data_in;
        if (en) begin
          state_d = BUSY;
          cnt_d   = 4'd0;
        end
      end

      BUSY: begin
        // cnt wraps 15 -> 0 on the final edge, so IDLE always holds cnt=0.
        cnt_d = cnt_q + 4'd1;
        if (cnt_q[1:0] == 2'd0) begin
          // Word boundary: emit d0 now, park d1..d3 for the next three edges.
          dout_d = d0;
          hold_d = {d1, d2, d3};
        end else begin
          dout_d = hold_q[23:16];
          hold_d = {hold_q[15:0], 8'h00};
        end
        // en is deliberately not examined here: no restart, no queueing.
        if (cnt_q == 4'd15) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign data_out    = dout_q;
  assign dbg_state_o = (state_q == BUSY);

endmodule

// File: tb/tb_pts_converter.sv
// -----------------------------------------------------------------------------
// tb_pts_converter
//
// Directed frames with constant expected byte tables, plus randomized traffic
// checked cycle by cycle against a frame-level reference model.
// Inputs change on the falling edge; DUT outputs are checked on the falling
// edge following the rising edge that produced them.
// -----------------------------------------------------------------------------
module tb_pts_converter;

  logic       clk;
  logic       rst;
  logic       en;
  logic [7:0] d0, d1, d2, d3;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       dbg_state_o;

  int n_checks;
  int n_pass;

  // Expected {busy, data_out} after each rising edge, produced by the model.
  logic [8:0] exp_q[$];

  logic [7:0]  pat   [16];
  logic [31:0] words [4];

  pts_converter dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .d0          (d0),
    .d1          (d1),
    .d2          (d2),
    .d3          (d3),
    .data_in     (data_in),
    .data_out    (data_out),
    .dbg_state_o (dbg_state_o)
  );

  // ---------------------------------------------------------------- clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------- checker
  task automatic check_eq(input string tag, input logic [31:0] obs,
                          input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- model
  // Frame-level view: a frame is 16 byte slots; slot p takes its word at
  // slot p%4==0 and emits byte p%4 of that word.
  int         m_pos   = -1;
  bit         m_armed = 1'b0;
  logic [7:0] m_word [4];

  always @(posedge clk) begin
    logic [7:0] exp_b;
    exp_b = 8'h00;
    if (rst) begin
      m_armed = 1'b1;
      m_pos   = -1;
      exp_b   = 8'h00;
    end else if (m_pos < 0) begin
      exp_b = data_in;
      if (en) m_pos = 0;
    end else begin
      if (m_pos % 4 == 0) begin
        m_word[0] = d0;
        m_word[1] = d1;
        m_word[2] = d2;
        m_word[3] = d3;
      end
      exp_b = m_word[m_pos % 4];
      m_pos++;
      if (m_pos == 16) m_pos = -1;
    end
    if (m_armed) exp_q.push_back({(m_pos >= 0), exp_b});
  end

  always @(negedge clk) begin
    logic [8:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_eq("model_dout", {24'd0, data_out}, {24'd0, e[7:0]});
      check_eq("model_busy", {31'd0, dbg_state_o}, {31'd0, e[8]});
    end
  end

  // ---------------------------------------------------------------- drivers
  // Apply inputs (called at a falling edge), then let one rising edge pass.
  task automatic drive_cycle(input logic e, input logic r, input logic [7:0] din,
                             input logic [31:0] w);
    en      = e;
    rst     = r;
    data_in = din;
    d0      = w[31:24];
    d1      = w[23:16];
    d2      = w[15:8];
    d3      = w[7:0];
    @(negedge clk);
  endtask

  // One frame with the reference pattern. glitch zeroes the word inputs on
  // non-sampling cycles; en_again / rst_at give the frame edge (1..16) of an
  // extra en or rst pulse (0 = none); start issues the en edge; chain raises
  // en on the edge after the frame.
  task automatic directed_frame(input bit glitch, input int en_again,
                                input int rst_at, input bit start,
                                input bit chain);
    logic [31:0] w;
    logic [7:0]  din;
    din = 8'hC3;
    if (start) begin
      drive_cycle(1'b1, 1'b0, 8'h3C, 32'hDEADBEEF);
      check_eq("start_bypass", {24'd0, data_out}, 32'h3C);
    end
    for (int j = 0; j < 16; j++) begin
      if (glitch && (j % 4) != 0) w = 32'h0;
      else                        w = words[j / 4];
      drive_cycle(en_again == j + 1, rst_at == j + 1, din, w);
      if (rst_at == 0 || j + 1 < rst_at)
        check_eq("frame_byte", {24'd0, data_out}, {24'd0, pat[j]});
      else if (j + 1 == rst_at)
        check_eq("rst_mid_dout", {24'd0, data_out}, 32'h00);
      else
        check_eq("rst_mid_bypass", {24'd0, data_out}, {24'd0, din});
    end
    drive_cycle(chain, 1'b0, 8'hE7, 32'h0);
    check_eq("after_frame", {24'd0, data_out}, 32'hE7);
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    n_checks = 0;
    n_pass   = 0;
    pat = '{8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77,
            8'h88, 8'h99, 8'haa, 8'hbb, 8'hcc, 8'hdd, 8'hee, 8'hff};
    for (int i = 0; i < 4; i++)
      words[i] = {pat[4*i], pat[4*i+1], pat[4*i+2], pat[4*i+3]};

    // Reset then idle bypass.
    rst = 1'b1; en = 1'b0; data_in = 8'h5A;
    d0 = 8'h00; d1 = 8'h00; d2 = 8'h00; d3 = 8'h00;
    @(negedge clk);
    check_eq("rst_dout", {24'd0, data_out}, 32'h00);
    check_eq("rst_idle", {31'd0, dbg_state_o}, 32'h0);
    drive_cycle(1'b0, 1'b0, 8'h5A, 32'h0);
    check_eq("idle_bypass", {24'd0, data_out}, 32'h5A);

    // Plain frame, then the same with glitching word inputs.
    directed_frame(1'b0, 0, 0, 1'b1, 1'b0);
    directed_frame(1'b1, 0, 0, 1'b1, 1'b0);

    // Pattern on the word inputs without en: pure bypass of 8'h00.
    for (int j = 0; j < 16; j++) begin
      drive_cycle(1'b0, 1'b0, 8'h00, words[j / 4]);
      check_eq("no_en_dout", {24'd0, data_out}, 32'h00);
    end

    // en mid-frame is ignored; en right after the frame starts a new one.
    directed_frame(1'b0, 6, 0, 1'b1, 1'b1);
    directed_frame(1'b0, 0, 0, 1'b0, 1'b0);

    // en on the final frame edge is ignored.
    directed_frame(1'b0, 16, 0, 1'b1, 1'b0);

    // Reset mid-frame.
    directed_frame(1'b0, 0, 8, 1'b1, 1'b0);

    // en held high: frames alternate with single bypass cycles.
    for (int i = 0; i < 40; i++)
      drive_cycle(1'b1, 1'b0, 8'($urandom_range(0, 255)), $urandom);
    for (int i = 0; i < 20; i++)
      drive_cycle(1'b0, 1'b0, 8'($urandom_range(0, 255)), $urandom);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 1500; i++) begin
      drive_cycle($urandom_range(0, 7) == 0, $urandom_range(0, 99) == 0,
                  8'($urandom_range(0, 255)), $urandom);
    end
    drive_cycle(1'b0, 1'b0, 8'h00, 32'h0);
    drive_cycle(1'b0, 1'b0, 8'h00, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
